// File: rtl/tone_sequencer.sv
// Programmable square-wave note sequencer: plays one of NUM_SEQ runtime-written
// sequences of {half-period, duration} entries, with loop, abort and inter-note gaps.
module tone_sequencer #(
    parameter int NUM_SEQ      = 8,
    parameter int SEQ_LEN      = 16,
    parameter int HP_W         = 18,
    parameter int DUR_W        = 8,
    parameter int TICK_CYCLES  = 1000000,
    parameter int GAP_TICKS    = 1,
    localparam int SEL_W       = $clog2(NUM_SEQ),
    localparam int IDX_W       = $clog2(SEQ_LEN)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [SEL_W-1:0] seq_sel_i,
    input  logic             loop_en_i,
    input  logic             abort_i,
    input  logic             wr_en_i,
    input  logic [SEL_W-1:0] wr_seq_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [HP_W-1:0]  wr_hp_i,
    input  logic [DUR_W-1:0] wr_dur_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             audio_end_o,
    output logic [IDX_W-1:0] note_idx_o,
    output logic             pwm_pin_o,
    output logic             amp_pin_o
);
    localparam int               TC_W      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TC_W-1:0]  TICK_LAST = TC_W'(TICK_CYCLES - 1);
    localparam logic [DUR_W-1:0] GAP_LAST  = (GAP_TICKS > 0) ? DUR_W'(GAP_TICKS - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(SEQ_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP, S_DONE} state_e;

    state_e           state_q;
    logic [SEL_W-1:0] sel_q;
    logic             loop_q;
    logic [IDX_W-1:0] note_idx_q;
    logic [HP_W-1:0]  hp_q;
    logic [HP_W-1:0]  hp_cnt_q;
    logic [DUR_W-1:0] dur_q;
    logic [DUR_W-1:0] ticks_q;
    logic [TC_W-1:0]  presc_q;
    logic             busy_q;
    logic             done_q;
    logic             audio_end_q;
    logic             pwm_q;
    logic             amp_q;

    logic [HP_W+DUR_W-1:0] mem_q [NUM_SEQ][SEQ_LEN];
    logic [HP_W+DUR_W-1:0] rd_q;
    logic [SEL_W-1:0]      rd_sel_d;
    logic [IDX_W-1:0]      rd_idx_d;
    logic [IDX_W-1:0]      next_idx;
    logic [HP_W-1:0]       rd_hp;
    logic [DUR_W-1:0]      rd_dur;
    logic                  last_entry;
    logic                  tick_end;
    logic                  phase_end;

    assign rd_hp      = rd_q[HP_W+DUR_W-1:DUR_W];
    assign rd_dur     = rd_q[DUR_W-1:0];
    assign last_entry = (note_idx_q == IDX_LAST);
    assign next_idx   = last_entry ? '0 : note_idx_q + 1'b1;
    assign tick_end   = (presc_q == TICK_LAST);
    // One counter pair times both the note (dur ticks) and the gap (GAP_TICKS ticks).
    assign phase_end  = tick_end &&
                        (ticks_q == ((state_q == S_GAP) ? GAP_LAST : dur_q - 1'b1));

    // Address the entry LOAD will need one cycle ahead, to cover the read latency.
    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    always_comb begin
        rd_sel_d = sel_q;
        rd_idx_d = next_idx;
        if (state_q == S_IDLE) begin
            rd_sel_d = seq_sel_i;
            rd_idx_d = '0;
        end else if (state_q == S_LOAD) begin
            rd_idx_d = '0;
        end
    end

    // NOTE: the sequence RAM is deliberately left out of reset; it is loaded through the write port before use.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_seq_i][wr_idx_i] <= {wr_hp_i, wr_dur_i};
        end
        rd_q <= mem_q[rd_sel_d][rd_idx_d];
    end

    // NOTE: sequential state uses non-blocking assignments only; later assignments in this block override earlier ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            loop_q      <= 1'b0;
            note_idx_q  <= '0;
            hp_q        <= '0;
            hp_cnt_q    <= '0;
            dur_q       <= '0;
            ticks_q     <= '0;
            presc_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            audio_end_q <= 1'b1;
            pwm_q       <= 1'b0;
            amp_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i && busy_q) begin
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
                pwm_q       <= 1'b0;
                amp_q       <= 1'b0;
                audio_end_q <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            state_q     <= S_LOAD;
                            sel_q       <= seq_sel_i;
                            loop_q      <= loop_en_i;
                            note_idx_q  <= '0;
                            audio_end_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        if (rd_dur == '0) begin
                            if (loop_q && note_idx_q != '0) begin
                                note_idx_q <= '0;
                            end else begin
                                state_q     <= S_DONE;
                                busy_q      <= 1'b0;
                                done_q      <= 1'b1;
                                audio_end_q <= 1'b1;
                            end
                        end else begin
                            state_q  <= S_PLAY;
                            hp_q     <= rd_hp;
                            dur_q    <= rd_dur;
                            presc_q  <= '0;
                            ticks_q  <= '0;
                            hp_cnt_q <= '0;
                            pwm_q    <= 1'b0;
                            amp_q    <= (rd_hp != '0);
                        end
                    end
                    S_PLAY, S_GAP: begin
                        presc_q <= tick_end ? '0 : presc_q + 1'b1;
                        if (tick_end) begin
                            ticks_q <= phase_end ? '0 : ticks_q + 1'b1;
                        end
                        if (state_q == S_PLAY && hp_q != '0) begin
                            if (hp_cnt_q == hp_q - 1'b1) begin
                                hp_cnt_q <= '0;
                                pwm_q    <= ~pwm_q;
                            end else begin
                                hp_cnt_q <= hp_cnt_q + 1'b1;
                            end
                        end
                        if (phase_end) begin
                            pwm_q <= 1'b0;
                            amp_q <= 1'b0;
                            if (state_q == S_PLAY && GAP_TICKS != 0) begin
                                state_q <= S_GAP;
                            end else if (!last_entry || loop_q) begin
                                note_idx_q <= next_idx;
                                state_q    <= S_LOAD;
                            end else begin
                                state_q     <= S_DONE;
                                busy_q      <= 1'b0;
                                done_q      <= 1'b1;
                                audio_end_q <= 1'b1;
                            end
                        end
                    end
                    S_DONE:  state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign audio_end_o = audio_end_q;
    assign note_idx_o  = note_idx_q;
    assign pwm_pin_o   = pwm_q;
    assign amp_pin_o   = amp_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: directed scenarios plus randomized sequences, checked
// cycle by cycle against an expected-output trace derived from the playback rules.
module tb_tone_sequencer;
    localparam int NSEQ = 8;
    localparam int LEN  = 4;
    localparam int TC   = 4;
    localparam int GAP  = 1;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       aend;
        logic [1:0] idx;
        logic       pwm;
        logic       amp;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  seq_sel;
    logic        loop_en;
    logic        abort;
    logic        wr_en;
    logic [2:0]  wr_seq;
    logic [1:0]  wr_idx;
    logic [17:0] wr_hp;
    logic [7:0]  wr_dur;
    logic        busy;
    logic        done;
    logic        audio_end;
    logic [1:0]  note_idx;
    logic        pwm_pin;
    logic        amp_pin;

    int   tests = 0;
    int   fails = 0;
    int   m_hp  [NSEQ][LEN];
    int   m_dur [NSEQ][LEN];
    obs_t exp_q [$];

    tone_sequencer #(
        .NUM_SEQ(NSEQ), .SEQ_LEN(LEN), .HP_W(18), .DUR_W(8),
        .TICK_CYCLES(TC), .GAP_TICKS(GAP)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .seq_sel_i(seq_sel),
        .loop_en_i(loop_en), .abort_i(abort), .wr_en_i(wr_en), .wr_seq_i(wr_seq),
        .wr_idx_i(wr_idx), .wr_hp_i(wr_hp), .wr_dur_i(wr_dur), .busy_o(busy),
        .done_o(done), .audio_end_o(audio_end), .note_idx_o(note_idx),
        .pwm_pin_o(pwm_pin), .amp_pin_o(amp_pin)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic obs_t mk(input bit b, input bit d, input bit a, input int i,
                                input bit p, input bit m);
        obs_t o;
        o.busy = b; o.done = d; o.aend = a; o.idx = 2'(i); o.pwm = p; o.amp = m;
        return o;
    endfunction

    task automatic check(input string tag, input obs_t want);
        obs_t got;
        got = {busy, done, audio_end, note_idx, pwm_pin, amp_pin};
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed busy/done/aend/idx/pwm/amp=%b/%b/%b/%0d/%b/%b expected %b/%b/%b/%0d/%b/%b",
                   tag, got.busy, got.done, got.aend, got.idx, got.pwm, got.amp,
                   want.busy, want.done, want.aend, want.idx, want.pwm, want.amp);
        end
    endtask

    // Called right after a falling edge; the entry is written on the next rising edge.
    task automatic write_entry(input int s, input int i, input int h, input int d);
        wr_en = 1'b1; wr_seq = 3'(s); wr_idx = 2'(i); wr_hp = 18'(h); wr_dur = 8'(d);
        m_hp[s][i] = h; m_dur[s][i] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Expected outputs for each cycle after the start edge, straight from the playback rules.
    task automatic build(input int sel, input bit loop, input int limit);
        int  idx;
        int  hp;
        bit  fin;
        idx = 0;
        fin = 1'b0;
        exp_q.delete();
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0));
        while (!fin && exp_q.size() < limit) begin
            if (m_dur[sel][idx] == 0) begin
                if (loop && idx != 0) begin
                    idx = 0;
                    exp_q.push_back(mk(1, 0, 0, 0, 0, 0));
                end else begin
                    fin = 1'b1;
                end
            end else begin
                hp = m_hp[sel][idx];
                for (int c = 1; c <= m_dur[sel][idx] * TC; c++)
                    exp_q.push_back(mk(1, 0, 0, idx, (hp != 0) && (((c - 1) / hp) % 2 == 1), hp != 0));
                for (int g = 0; g < GAP * TC; g++)
                    exp_q.push_back(mk(1, 0, 0, idx, 0, 0));
                if (idx < LEN - 1) idx++;
                else if (loop) idx = 0;
                else fin = 1'b1;
                if (!fin) exp_q.push_back(mk(1, 0, 0, idx, 0, 0));
            end
        end
        if (fin) begin
            exp_q.push_back(mk(0, 1, 1, idx, 0, 0));
            exp_q.push_back(mk(0, 0, 1, idx, 0, 0));
        end
        while (exp_q.size() > limit) void'(exp_q.pop_back());
    endtask

    // start_at < 0 counts back from the end (-1 = the DONE cycle); wr_at = 0 means no write.
    task automatic play(input string tag, input int sel, input bit loop, input int abort_at,
                        input int start_at, input bit abort_with_start, input int wr_at,
                        input int ws, input int wi, input int wh, input int wd);
        bit do_abort;
        int pulse_at;
        do_abort = 1'b0;
        if (wr_at > 0) begin
            m_hp[ws][wi]  = wh;
            m_dur[ws][wi] = wd;
        end
        build(sel, loop, (abort_at > 0) ? abort_at : 2000);
        if (abort_at > 0 && exp_q.size() == abort_at && exp_q[abort_at - 1].busy) begin
            do_abort = 1'b1;
            exp_q.push_back(mk(0, 0, 1, int'(exp_q[abort_at - 1].idx), 0, 0));
        end
        pulse_at = (start_at < 0) ? exp_q.size() + start_at : start_at;
        @(negedge clk);
        start = 1'b1; seq_sel = 3'(sel); loop_en = loop; abort = abort_with_start;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0; wr_en = 1'b0;
            seq_sel = 3'($urandom); loop_en = 1'($urandom);
            check($sformatf("%s c%0d", tag, k + 1), exp_q[k]);
            if (k + 1 == pulse_at && k + 1 < exp_q.size()) begin
                start = 1'b1; seq_sel = 3'((sel + 1) % NSEQ);
            end
            if (k + 1 == wr_at) begin
                wr_en = 1'b1; wr_seq = 3'(ws); wr_idx = 2'(wi); wr_hp = 18'(wh); wr_dur = 8'(wd);
            end
            if (do_abort && k + 1 == abort_at) abort = 1'b1;
        end
        start = 1'b0; abort = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        int s;
        int ab;
        bit lp;
        rst_n = 1'b0; start = 1'b0; seq_sel = '0; loop_en = 1'b0; abort = 1'b0;
        wr_en = 1'b0; wr_seq = '0; wr_idx = '0; wr_hp = '0; wr_dur = '0;
        repeat (3) @(negedge clk);
        check("reset", mk(0, 0, 1, 0, 0, 0));
        rst_n = 1'b1;
        for (int i = 0; i < NSEQ; i++)
            for (int j = 0; j < LEN; j++) write_entry(i, j, 0, 0);

        // Tone, rest, end marker; a start while busy and one during DONE are both ignored.
        write_entry(2, 0, 3, 2);
        write_entry(2, 1, 0, 1);
        write_entry(2, 2, 0, 0);
        write_entry(2, 3, 5, 3);
        play("seq2", 2, 0, 0, 5, 0, 0, 0, 0, 0, 0);
        play("seq2_start_in_done", 2, 0, 0, -1, 0, 0, 0, 0, 0, 0);

        // Full sequence ending on wrap-around, then looping until aborted in the second pass.
        write_entry(1, 0, 2, 1);
        write_entry(1, 1, 1, 1);
        write_entry(1, 2, 3, 2);
        write_entry(1, 3, 4, 1);
        play("seq1_once", 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        play("seq1_loop", 1, 1, 55, 20, 0, 0, 0, 0, 0, 0);

        play("seq0_empty_loop", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        play("seq2_abort", 2, 0, 6, 0, 0, 0, 0, 0, 0, 0);

        // Entry 3 rewritten while entry 0 is sounding.
        write_entry(3, 0, 2, 2);
        write_entry(3, 1, 1, 1);
        write_entry(3, 2, 0, 1);
        write_entry(3, 3, 2, 1);
        play("seq3_late_write", 3, 0, 0, 0, 0, 3, 3, 3, 1, 2);

        // Asynchronous reset in the middle of a sounding note.
        @(negedge clk);
        start = 1'b1; seq_sel = 3'd2; loop_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_reset_note", mk(1, 0, 0, 0, 1, 1));
        #2 rst_n = 1'b0;
        #1 check("mid_note_reset", mk(0, 0, 1, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        play("seq2_after_reset", 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int r = 0; r < 8; r++) begin
            s = 4 + $urandom_range(0, 3);
            for (int j = 0; j < LEN; j++)
                write_entry(s, j, $urandom_range(0, 4), $urandom_range(0, 3));
            lp = 1'($urandom_range(0, 1));
            if (lp) ab = $urandom_range(2, 70);
            else ab = $urandom_range(0, 1) ? $urandom_range(2, 40) : 0;
            play($sformatf("rand%0d", r), s, lp, ab, 0, 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Parametrised successor to the fixed-table audio sequence player.
- Plays one of NUM_SEQ programmable note sequences as a square wave on pwm_pin. Each note is defined by a half-period and a duration.
- Adds runtime-writable sequence memory, loop mode, abort, an inter-note gap, and a start/busy/done handshake.
- Sits between the game FSM (start, select, end status) and the board amplifier pins.

Parameters:
NUM_SEQ, 8, number of sequences; SEL_W = clog2(NUM_SEQ)
SEQ_LEN, 16, max entries per sequence; IDX_W = clog2(SEQ_LEN)
HP_W, 18, half-period count width in clk cycles; 0 = rest
DUR_W, 8, note duration width in ticks; 0 = end marker
TICK_CYCLES, 1000000, clk cycles per duration tick (10 ms at 100 MHz)
GAP_TICKS, 1, silent ticks between notes; 0 = no gap

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to play seq_sel; honoured only when busy=0
seq_sel  in  SEL_W  sequence to play; sampled with start
loop_en  in  1  sampled with start; 1 = replay the sequence until abort
abort  in  1  stop playback immediately
wr_en  in  1  write one sequence-memory entry
wr_seq  in  SEL_W  sequence being written
wr_idx  in  IDX_W  entry being written
wr_hp  in  HP_W  half-period of the entry
wr_dur  in  DUR_W  duration of the entry
busy  out  1  high in LOAD/PLAY/GAP
done  out  1  one-cycle pulse on normal sequence completion
audio_end  out  1  level: set on completion or abort, cleared on accepted start
note_idx  out  IDX_W  index of the current entry
pwm_pin  out  1  square-wave output
amp_pin  out  1  amplifier enable; high only while a non-rest note is sounding

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0, audio_end=1, note_idx=0, pwm_pin=0, amp_pin=0; all counters 0.
- Sequence memory:
  - NUM_SEQ*SEQ_LEN entries of {hp, dur}, written synchronously when wr_en=1, accepted in any state.
  - Memory contents are not reset; the bench initialises memory before use.
  - Read is synchronous, one-cycle latency.
  - A write to an entry not yet loaded takes effect when that entry is loaded.
- State machine: IDLE, LOAD, PLAY, GAP, DONE.
- IDLE: start=1 → LOAD at the next edge. Latch seq_sel and loop_en; note_idx=0; audio_end=0.
- LOAD (1 cycle):
  - dur==0 with loop=0 → DONE.
  - dur==0 with loop=1 and note_idx!=0 → note_idx=0, stay in LOAD.
  - dur==0 at note_idx=0 → DONE regardless of loop, so an empty sequence cannot hang.
  - Otherwise → PLAY: load hp and dur; reset the tick prescaler and the half-period counter; pwm_pin=0.
- PLAY:
  - Note lasts exactly dur*TICK_CYCLES cycles.
  - hp!=0: amp_pin=1; pwm_pin toggles every hp cycles, first toggle hp cycles after entering PLAY.
  - hp==0 (rest): pwm_pin=0, amp_pin=0.
  - At the end of the note, pwm_pin=0 and amp_pin=0. GAP_TICKS!=0 → GAP; GAP_TICKS==0 → next entry directly.
- GAP: silent for GAP_TICKS*TICK_CYCLES cycles, then next entry.
- Next entry:
  - note_idx < SEQ_LEN-1 → increment, LOAD.
  - note_idx == SEQ_LEN-1 (wrap-around) → loop=1: note_idx=0, LOAD; loop=0: DONE.
- DONE (1 cycle): done=1, audio_end=1, → IDLE.
- abort=1 in any busy state:
  - Next edge → IDLE.
  - pwm_pin=0, amp_pin=0, audio_end=1; done is not pulsed; note_idx holds its last value.
  - Abort has priority over every internal transition.
  - Abort in IDLE has no effect.
- start while busy, or in DONE: ignored.
- start and abort in the same cycle in IDLE: start wins.
- Outputs are registered; busy drops to 0 on the same edge that enters DONE or IDLE.

Test Plan:
- Defaults: TICK_CYCLES=4, SEQ_LEN=4, GAP_TICKS=1.
- Reset mid-note → all outputs at reset values immediately. After release, start plays from note_idx 0.
- seq 2 = {hp=3,dur=2},{hp=0,dur=1},{dur=0}; start, seq_sel=2:
  - pwm toggles every 3 cycles for 8 cycles with amp=1.
  - 4-cycle gap; 4 silent rest cycles; 4-cycle gap.
  - done pulses once, audio_end=1.
- seq 1 has all 4 entries non-zero, loop_en=0 → note_idx runs 0..3, then DONE (wrap-around end). Repeat with loop_en=1 → note_idx returns to 0 and play continues until abort.
- seq 0 entry0 dur=0 with loop_en=1 → DONE two cycles after start, no pwm activity.
- abort during PLAY → next edge: pwm=0, amp=0, busy=0, audio_end=1, done stays 0.
- start pulsed while busy → ignored, sequence unchanged.
- Write to entry 3 while entry 0 plays → new value is heard at entry 3.
